udp_payload_buffer: RTL and testbench
=====================================

// Module: udp_payload_buffer
// PURPOSE
// Single-frame payload store that sits directly upstream of the UDP coder. It collects one
// application payload byte stream, and as the bytes arrive it computes the payload length and
// the folded 16-bit one's-complement sum. When the coder's data request arrives, it replays the
// payload as a gap-free byte burst with a valid strobe. Its outputs drive the coder's payload
// data, valid, length and data-checksum inputs.
// PARAMETERS
// DEPTH   1472  payload capacity in bytes (max unfragmented UDP payload)
// ADDR_W  11    address/count width; 2**ADDR_W >= DEPTH
// PORTS
// CLK             in   1   single clock
// RST             in   1   synchronous, active-high reset
// WR_DATA         in   8   payload byte from application
// WR_VLD          in   1   WR_DATA valid; accepted only when WR_RDY=1
// WR_LAST         in   1   marks last byte; qualified by WR_VLD
// WR_RDY          out  1   buffer accepting bytes (IDLE/FILL)
// FRAME_RDY       out  1   complete frame held; drives frame-start to coder controller
// OVERFLOW        out  1   sticky: current frame exceeded DEPTH and was discarded
// DATA_REQUEST    in   1   from coder; starts replay
// OUT_DATA        out  8   payload byte to coder
// OUT_DATA_VLD    out  1   OUT_DATA valid
// OUT_LENGTH      out  16  payload byte count (zero-extended)
// OUT_CHECKSUM    out  16  folded one's-complement sum of payload, NOT inverted
// BEHAVIOUR
// - Reset (sync): state IDLE; WR_RDY=1; FRAME_RDY, OVERFLOW, OUT_DATA_VLD=0;
//   OUT_DATA, OUT_LENGTH, OUT_CHECKSUM=0; write ptr, read ptr, accumulator cleared.
//   Reset mid-fill or mid-replay abandons the frame immediately.
// - States: IDLE -> FILL (first accepted byte without LAST) or READY (single-byte frame);
//   FILL -> READY on accepted LAST; READY -> READ on DATA_REQUEST=1; READ -> IDLE after last byte.
//   FILL -> DROP when byte DEPTH+1 is accepted; DROP -> IDLE on LAST.
// - WR_RDY=1 only in IDLE/FILL/DROP. WR_VLD is ignored in READY/READ.
// - Storage: byte n is written to RAM[n], n = 0..DEPTH-1. The RAM is inferred (BRAM-friendly)
//   with a registered read.
// - Checksum: even-index bytes form the high byte and odd-index bytes the low byte of a 16-bit
//   word. Each word is added with end-around carry into a 16-bit accumulator: acc = s[15:0] + s[16].
//   For an odd length, the last byte is padded with a 0x00 low byte at LAST.
//   Accumulation is on the fly; OUT_CHECKSUM is final when FRAME_RDY rises.
// - OUT_LENGTH and OUT_CHECKSUM are updated on entry to READY. They are held stable through
//   READ and until the next frame reaches READY.
// - FRAME_RDY=1 in READY only. It falls in the cycle after DATA_REQUEST is sampled.
// - Replay latency: DATA_REQUEST sampled high at edge k -> OUT_DATA_VLD=1 with byte 0 after
//   edge k+1. Byte 0 is pre-fetched in READY so there is no extra bubble.
// - OUT_DATA_VLD stays high for exactly OUT_LENGTH consecutive cycles with no gaps, then goes low.
//   OUT_DATA=0 whenever VLD=0.
// - DATA_REQUEST in IDLE/FILL/DROP/READ is ignored. A request held high for several cycles
//   starts only one replay.
// - Overflow: bytes beyond DEPTH are not stored. OVERFLOW=1 from that byte until the next frame's
//   first accepted byte. The frame never reaches READY. Accumulator and count restart at 0.
// - Length counter is ADDR_W+1 bits; it saturates at DEPTH and never wraps.
// TESTING
// 1) Write 01 02 03 04 (LAST on 04) -> FRAME_RDY=1, OUT_LENGTH=4, OUT_CHECKSUM=0x0406.
// 2) Write AA BB CC (odd length) -> OUT_LENGTH=3, OUT_CHECKSUM=0x76BC (AABB+CC00 folded).
// 3) Write FF FF 00 01 -> OUT_CHECKSUM=0x0001 (end-around carry).
// 4) Pulse DATA_REQUEST at edge k -> VLD high edges k+1..k+4, bytes 01 02 03 04 in order,
//    then VLD=0, state IDLE, WR_RDY=1.
// 5) DEPTH=8, write 9 bytes + LAST -> OVERFLOW=1, FRAME_RDY stays 0. Next 2-byte frame is
//    buffered correctly and OVERFLOW clears.
// 6) RST=1 for one cycle mid-replay -> VLD=0, FRAME_RDY=0 next edge. New frame written
//    afterwards replays correctly. WR_VLD during READ is ignored.

Source files
------------

// File: rtl/udp_payload_buffer.sv
// Single-frame payload buffer ahead of the UDP coder: stores one payload, computes its length and
// folded one's-complement sum while filling, then replays it as a gap-free burst on request.
module udp_payload_buffer #(
   parameter int DEPTH  = 1472,
   parameter int ADDR_W = 11
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  WR_DATA,
   input  logic        WR_VLD,
   input  logic        WR_LAST,
   output logic        WR_RDY,
   output logic        FRAME_RDY,
   output logic        OVERFLOW,
   input  logic        DATA_REQUEST,
   output logic [7:0]  OUT_DATA,
   output logic        OUT_DATA_VLD,
   output logic [15:0] OUT_LENGTH,
   output logic [15:0] OUT_CHECKSUM
);

   typedef enum logic [2:0] {IDLE, FILL, READY, READ, DROP} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   state_t            state;
   logic [7:0]        mem [DEPTH];
   logic [7:0]        ram_q;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   len_next;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [15:0]       acc;
   logic [15:0]       cs_final;
   logic [7:0]        hi;
   logic              accept;
   logic              full;
   logic              we;

   assign accept   = WR_VLD && WR_RDY;
   assign full     = (cnt == DEPTH_C);
   assign we       = accept && ((state == IDLE) || (state == FILL)) && !full;
   assign wr_addr  = cnt[ADDR_W-1:0];
   assign rd_addr  = (rd_ptr < DEPTH_C) ? rd_ptr[ADDR_W-1:0] : '0;
   assign len_next = cnt + 1'b1;
   // An odd-length frame ends on a high byte, padded with a zero low byte.
   assign cs_final = cnt[0] ? add1c(acc, {hi, WR_DATA}) : add1c(acc, {WR_DATA, 8'h00});

   // Plain write port plus registered read keeps the array mappable to block RAM.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[wr_addr] <= WR_DATA;
      end
      ram_q <= mem[rd_addr];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         WR_RDY       <= 1'b1;
         FRAME_RDY    <= 1'b0;
         OVERFLOW     <= 1'b0;
         OUT_DATA_VLD <= 1'b0;
         OUT_DATA     <= 8'h00;
         OUT_LENGTH   <= 16'h0000;
         OUT_CHECKSUM <= 16'h0000;
         cnt          <= '0;
         rd_ptr       <= '0;
         acc          <= 16'h0000;
         hi           <= 8'h00;
      end else begin
         OUT_DATA_VLD <= 1'b0;
         OUT_DATA     <= 8'h00;
         case (state)
            IDLE, FILL: begin
               if (accept) begin
                  if (state == IDLE) begin
                     OVERFLOW <= 1'b0;
                  end
                  if (full) begin
                     // Byte DEPTH+1: discard the frame and swallow the rest up to LAST.
                     OVERFLOW <= 1'b1;
                     cnt      <= '0;
                     acc      <= 16'h0000;
                     state    <= WR_LAST ? IDLE : DROP;
                  end else if (WR_LAST) begin
                     OUT_LENGTH   <= 16'(len_next);
                     OUT_CHECKSUM <= cs_final;
                     FRAME_RDY    <= 1'b1;
                     WR_RDY       <= 1'b0;
                     cnt          <= '0;
                     acc          <= 16'h0000;
                     rd_ptr       <= '0;
                     state        <= READY;
                  end else begin
                     cnt   <= len_next;
                     state <= FILL;
                     if (cnt[0]) begin
                        acc <= add1c(acc, {hi, WR_DATA});
                     end else begin
                        hi <= WR_DATA;
                     end
                  end
               end
            end
            DROP: begin
               if (accept && WR_LAST) begin
                  state <= IDLE;
               end
            end
            READY: begin
               // ram_q already holds byte 0 here, so the burst starts one edge after the request.
               if (DATA_REQUEST) begin
                  FRAME_RDY <= 1'b0;
                  rd_ptr    <= {{ADDR_W{1'b0}}, 1'b1};
                  state     <= READ;
               end
            end
            READ: begin
               OUT_DATA_VLD <= 1'b1;
               OUT_DATA     <= ram_q;
               if (rd_ptr == OUT_LENGTH[ADDR_W:0]) begin
                  rd_ptr <= '0;
                  WR_RDY <= 1'b1;
                  state  <= IDLE;
               end else begin
                  rd_ptr <= rd_ptr + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               WR_RDY <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_payload_buffer.sv
// Scoreboard bench for udp_payload_buffer with a small DEPTH so overflow is reachable.
module tb_udp_payload_buffer;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  WR_DATA;
   logic        WR_VLD;
   logic        WR_LAST;
   logic        WR_RDY;
   logic        FRAME_RDY;
   logic        OVERFLOW;
   logic        DATA_REQUEST;
   logic [7:0]  OUT_DATA;
   logic        OUT_DATA_VLD;
   logic [15:0] OUT_LENGTH;
   logic [15:0] OUT_CHECKSUM;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  sb[$];
   bit          mon_en = 1'b0;
   logic [7:0]  fr[$];

   udp_payload_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .WR_DATA      (WR_DATA),
      .WR_VLD       (WR_VLD),
      .WR_LAST      (WR_LAST),
      .WR_RDY       (WR_RDY),
      .FRAME_RDY    (FRAME_RDY),
      .OVERFLOW     (OVERFLOW),
      .DATA_REQUEST (DATA_REQUEST),
      .OUT_DATA     (OUT_DATA),
      .OUT_DATA_VLD (OUT_DATA_VLD),
      .OUT_LENGTH   (OUT_LENGTH),
      .OUT_CHECKSUM (OUT_CHECKSUM)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [15:0] model_cs(input logic [7:0] f[$]);
      int unsigned s;
      int          n;
      s = 0;
      n = f.size();
      for (int i = 0; i < n; i += 2) begin
         s += {16'd0, f[i], ((i + 1 < n) ? f[i+1] : 8'h00)};
      end
      while ((s >> 16) != 0) begin
         s = (s & 32'h0000_FFFF) + (s >> 16);
      end
      return s[15:0];
   endfunction

   // Output side of the scoreboard: every valid byte must match the oldest expected byte.
   always @(negedge CLK) begin
      if (mon_en) begin
         if (OUT_DATA_VLD) begin
            if (sb.size() == 0) begin
               check_val("vld_with_empty_sb", {31'd0, OUT_DATA_VLD}, 32'd0);
            end else begin
               logic [7:0] e;
               e = sb.pop_front();
               check_val("out_data", {24'd0, OUT_DATA}, {24'd0, e});
            end
         end else begin
            check_val("out_data_zero_when_idle", {24'd0, OUT_DATA}, 32'd0);
         end
      end
   end

   task automatic write_frame(input logic [7:0] f[$], input bit gaps);
      int          n;
      logic [15:0] ecs;
      n   = f.size();
      ecs = model_cs(f);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            WR_VLD  = 1'b0;
            WR_LAST = 1'b1;
            WR_DATA = 8'($urandom);
            step();
         end
         check_val("wr_rdy_during_fill", {31'd0, WR_RDY}, 32'd1);
         WR_DATA = f[i];
         WR_VLD  = 1'b1;
         WR_LAST = (i == n - 1);
         step();
         check_val("overflow_flag", {31'd0, OVERFLOW}, (i >= DEPTH) ? 32'd1 : 32'd0);
      end
      WR_VLD  = 1'b0;
      WR_LAST = 1'b0;
      if (n <= DEPTH) begin
         foreach (f[i]) sb.push_back(f[i]);
         check_val("frame_rdy", {31'd0, FRAME_RDY}, 32'd1);
         check_val("wr_rdy_ready", {31'd0, WR_RDY}, 32'd0);
         check_val("out_length", {16'd0, OUT_LENGTH}, n);
         check_val("out_checksum", {16'd0, OUT_CHECKSUM}, {16'd0, ecs});
      end else begin
         check_val("frame_rdy_after_ovf", {31'd0, FRAME_RDY}, 32'd0);
         check_val("overflow_after_ovf", {31'd0, OVERFLOW}, 32'd1);
         check_val("wr_rdy_after_ovf", {31'd0, WR_RDY}, 32'd1);
      end
   endtask

   // DATA_REQUEST is high at edges k .. k+hold-1; noise drives WR_VLD during the burst.
   task automatic replay(input int len, input int hold, input bit noise);
      DATA_REQUEST = 1'b1;
      step();
      check_val("frame_rdy_falls", {31'd0, FRAME_RDY}, 32'd0);
      check_val("vld_not_yet", {31'd0, OUT_DATA_VLD}, 32'd0);
      for (int i = 1; i <= len; i++) begin
         if (i >= hold) DATA_REQUEST = 1'b0;
         if (noise) begin
            WR_VLD  = 1'b1;
            WR_LAST = 1'b1;
            WR_DATA = 8'($urandom);
         end
         step();
         check_val("vld_burst", {31'd0, OUT_DATA_VLD}, 32'd1);
         check_val("wr_rdy_in_read", {31'd0, WR_RDY}, (i == len) ? 32'd1 : 32'd0);
         check_val("length_held", {16'd0, OUT_LENGTH}, len);
      end
      WR_VLD       = 1'b0;
      WR_LAST      = 1'b0;
      DATA_REQUEST = 1'b0;
      step();
      check_val("vld_end", {31'd0, OUT_DATA_VLD}, 32'd0);
      check_val("wr_rdy_end", {31'd0, WR_RDY}, 32'd1);
      check_val("frame_rdy_end", {31'd0, FRAME_RDY}, 32'd0);
      check_val("sb_drained", sb.size(), 32'd0);
   endtask

   initial begin
      RST          = 1'b1;
      WR_DATA      = 8'h00;
      WR_VLD       = 1'b0;
      WR_LAST      = 1'b0;
      DATA_REQUEST = 1'b0;
      repeat (3) step();
      check_val("rst_wr_rdy", {31'd0, WR_RDY}, 32'd1);
      check_val("rst_frame_rdy", {31'd0, FRAME_RDY}, 32'd0);
      check_val("rst_overflow", {31'd0, OVERFLOW}, 32'd0);
      check_val("rst_vld", {31'd0, OUT_DATA_VLD}, 32'd0);
      check_val("rst_data", {24'd0, OUT_DATA}, 32'd0);
      check_val("rst_length", {16'd0, OUT_LENGTH}, 32'd0);
      check_val("rst_checksum", {16'd0, OUT_CHECKSUM}, 32'd0);
      RST    = 1'b0;
      mon_en = 1'b1;

      // A request while idle must not start anything.
      DATA_REQUEST = 1'b1;
      step();
      step();
      DATA_REQUEST = 1'b0;
      check_val("idle_req_vld", {31'd0, OUT_DATA_VLD}, 32'd0);
      check_val("idle_req_wr_rdy", {31'd0, WR_RDY}, 32'd1);

      fr = {8'h01, 8'h02, 8'h03, 8'h04};
      write_frame(fr, 1'b0);
      check_val("vec1_checksum", {16'd0, OUT_CHECKSUM}, 32'h0406);
      replay(4, 3, 1'b0);

      fr = {8'hAA, 8'hBB, 8'hCC};
      write_frame(fr, 1'b1);
      check_val("vec2_length", {16'd0, OUT_LENGTH}, 32'd3);
      check_val("vec2_checksum", {16'd0, OUT_CHECKSUM}, 32'h76BC);
      replay(3, 1, 1'b0);

      fr = {8'hFF, 8'hFF, 8'h00, 8'h01};
      write_frame(fr, 1'b0);
      check_val("vec3_checksum", {16'd0, OUT_CHECKSUM}, 32'h0001);
      replay(4, 6, 1'b0);

      fr = {8'h5A};
      write_frame(fr, 1'b0);
      check_val("single_checksum", {16'd0, OUT_CHECKSUM}, 32'h5A00);
      replay(1, 1, 1'b0);

      fr.delete();
      for (int i = 0; i < DEPTH; i++) fr.push_back(8'($urandom));
      write_frame(fr, 1'b1);
      replay(DEPTH, 2, 1'b0);

      // Overflow: LAST beyond the overflow byte, then LAST on the overflow byte itself.
      fr.delete();
      for (int i = 0; i < DEPTH + 2; i++) fr.push_back(8'($urandom));
      write_frame(fr, 1'b1);
      fr.delete();
      for (int i = 0; i < DEPTH + 1; i++) fr.push_back(8'($urandom));
      write_frame(fr, 1'b0);
      fr = {8'h12, 8'h34};
      write_frame(fr, 1'b0);
      check_val("post_ovf_checksum", {16'd0, OUT_CHECKSUM}, 32'h1234);
      replay(2, 1, 1'b0);

      // Reset in the middle of a burst abandons it.
      fr = {8'h10, 8'h20, 8'h30, 8'h40};
      write_frame(fr, 1'b0);
      DATA_REQUEST = 1'b1;
      step();
      DATA_REQUEST = 1'b0;
      step();
      check_val("pre_rst_vld", {31'd0, OUT_DATA_VLD}, 32'd1);
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      sb.delete();
      check_val("mid_rst_vld", {31'd0, OUT_DATA_VLD}, 32'd0);
      check_val("mid_rst_frame_rdy", {31'd0, FRAME_RDY}, 32'd0);
      check_val("mid_rst_wr_rdy", {31'd0, WR_RDY}, 32'd1);
      check_val("mid_rst_length", {16'd0, OUT_LENGTH}, 32'd0);

      fr = {8'hC3, 8'h3C, 8'h7E, 8'hE7, 8'h01};
      write_frame(fr, 1'b1);
      replay(5, 1, 1'b1);

      for (int f = 0; f < 4; f++) begin
         int n;
         n = $urandom_range(1, DEPTH);
         fr.delete();
         for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
         write_frame(fr, 1'b1);
         replay(n, $urandom_range(1, 3), f[0]);
      end

      repeat (3) step();
      check_val("final_sb_empty", sb.size(), 32'd0);
      check_val("final_vld", {31'd0, OUT_DATA_VLD}, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
